// File: rtl/regfile_param.sv
// Parametrised integer register file with a post-reset clearing sweep.
//   XLEN / NREGS / NREAD / ZERO_REG configure width, depth, read ports and
//   the hardwired-zero register; AW is derived from NREGS.
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a write accepted this cycle is forwarded to matching read ports
//   undefined -> reads always show the stored contents (no rd/write -> rs path)
//
// FSM states
//   state | meaning
//   CLEAR | sweep writing 0 to mem[clr_cnt]; busy=1, writes dropped, reads 0
//   READY | normal operation; writes accepted, reads return stored data
module regfile_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs,
  input  logic [AW-1:0]         rd_addr,
  input  logic [XLEN-1:0]       rd,
  input  logic                  write,
  output logic                  busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   clr_cnt;
  logic [AW-1:0]   clr_cnt_next;

  logic [XLEN-1:0] mem [NREGS];

  logic            wr_accept;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  // Addresses at or above NREGS exist only when NREGS is not a power of two;
  // widening by one bit keeps the compare meaningful for every NREGS.
  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(NREGS));
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // State register and sweep counter; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // Next-state logic: advance the sweep, leave CLEAR after the last entry.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    case (state)
      CLEAR: begin
        if (clr_cnt == LAST_IDX) begin
          state_next   = READY;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt + 1'b1;
        end
      end
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  // Output logic: busy flag and the single memory write port selection.
  // The reset cycle performs no memory write at all.
  always_comb begin
    busy      = (state == CLEAR);
    wr_accept = (state == READY) && write && in_range(rd_addr) && !is_zero_reg(rd_addr);
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = '0;
      end else if (wr_accept) begin
        mem_we    = 1'b1;
        mem_waddr = rd_addr;
        mem_wdata = rd;
      end
    end
  end

  // Storage array; no reset of its own, the sweep provides the clearing.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Combinational read ports; busy, zero-reg and range masking beat the data.
  for (genvar g = 0; g < NREAD; g++) begin : g_read
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    assign addr = rs_addr[g*AW +: AW];

    // Select the value seen on this port in the current cycle.
    always_comb begin
      data = '0;
      if (busy || is_zero_reg(addr) || !in_range(addr)) begin
        data = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_accept && (addr == rd_addr)) begin
        data = rd;
`endif
      end else begin
        data = mem[addr];
      end
    end

    assign rs[g*XLEN +: XLEN] = data;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Randomised scoreboard bench for regfile_param. Two instances:
//   a: NREGS=32 NREAD=2 ZERO_REG=1     b: NREGS=24 NREAD=3 ZERO_REG=0
// Expected read data and busy come from an array model plus a "sweep cycles
// remaining" counter, pushed per cycle and popped by an independent monitor.
module tb_regfile_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, write_a, busy_a;
  logic [4:0]  rd_addr_a;
  logic [31:0] rd_a;
  logic [9:0]  rs_addr_a;
  logic [63:0] rs_a;

  logic        reset_b, write_b, busy_b;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_b;
  logic [14:0] rs_addr_b;
  logic [95:0] rs_b;

  regfile_param #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset(reset_a), .rs_addr(rs_addr_a), .rs(rs_a),
    .rd_addr(rd_addr_a), .rd(rd_a), .write(write_a), .busy(busy_a)
  );

  regfile_param #(.XLEN(32), .NREGS(24), .NREAD(3), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(reset_b), .rs_addr(rs_addr_b), .rs(rs_b),
    .rd_addr(rd_addr_b), .rd(rd_b), .write(write_b), .busy(busy_b)
  );

  typedef struct packed {
    logic        busy_a;
    logic [63:0] rs_a;
    logic        busy_b;
    logic [95:0] rs_b;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int errors = 0;
  int checks = 0;

  // Behavioural model: register contents and remaining sweep cycles per DUT.
  logic [31:0] mem_m [2][32];
  int          left_m [2];

  function automatic int nr(input int d);
    return (d == 0) ? 32 : 24;
  endfunction

  function automatic bit zr(input int d);
    return (d == 0);
  endfunction

  function automatic bit accepted(input int d, input logic wr, input int wa);
    return wr && (wa < nr(d)) && !(zr(d) && wa == 0);
  endfunction

  function automatic logic [31:0] exp_read(input int d, input int addr, input logic wr,
                                           input int wa, input logic [31:0] wd);
    if (left_m[d] > 0) return 32'h0;
    if (addr >= nr(d)) return 32'h0;
    if (zr(d) && addr == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (accepted(d, wr, wa) && addr == wa) return wd;
`endif
    return mem_m[d][addr];
  endfunction

  task automatic model_edge(input int d, input logic rst, input logic wr,
                            input int wa, input logic [31:0] wd);
    if (rst) begin
      left_m[d] = nr(d);
      for (int k = 0; k < 32; k++) mem_m[d][k] = 32'h0;
    end else if (left_m[d] > 0) begin
      left_m[d] = left_m[d] - 1;
    end else if (accepted(d, wr, wa)) begin
      mem_m[d][wa] = wd;
    end
  endtask

  // One clock of stimulus: predict this cycle's outputs, then advance the model.
  task automatic cycle();
    exp_t e;
    e.busy_a = (left_m[0] > 0);
    for (int i = 0; i < 2; i++)
      e.rs_a[i*32 +: 32] = exp_read(0, int'(rs_addr_a[i*5 +: 5]), write_a, int'(rd_addr_a), rd_a);
    e.busy_b = (left_m[1] > 0);
    for (int i = 0; i < 3; i++)
      e.rs_b[i*32 +: 32] = exp_read(1, int'(rs_addr_b[i*5 +: 5]), write_b, int'(rd_addr_b), rd_b);
    exp_q.push_back(e);
    @(posedge clk);
    model_edge(0, reset_a, write_a, int'(rd_addr_a), rd_a);
    model_edge(1, reset_b, write_b, int'(rd_addr_b), rd_b);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("busy_a", {31'h0, busy_a}, {31'h0, mon_e.busy_a});
      for (int i = 0; i < 2; i++)
        chk($sformatf("rs_a[%0d]", i), rs_a[i*32 +: 32], mon_e.rs_a[i*32 +: 32]);
      chk("busy_b", {31'h0, busy_b}, {31'h0, mon_e.busy_b});
      for (int i = 0; i < 3; i++)
        chk($sformatf("rs_b[%0d]", i), rs_b[i*32 +: 32], mon_e.rs_b[i*32 +: 32]);
    end
  end

  task automatic rand_in();
    reset_a   = 1'b0;
    reset_b   = 1'b0;
    write_a   = 1'($urandom_range(0, 1));
    write_b   = 1'($urandom_range(0, 1));
    rd_addr_a = 5'($urandom_range(0, 31));
    rd_addr_b = 5'($urandom_range(0, 31));
    rd_a      = $urandom;
    rd_b      = $urandom;
    rs_addr_a = 10'($urandom);
    rs_addr_b = 15'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      rs_addr_a[4:0] = rd_addr_a;
      rs_addr_b[4:0] = rd_addr_b;
    end
  endtask

  task automatic read_all();
    write_a = 1'b0;
    write_b = 1'b0;
    for (int r = 0; r < 32; r += 2) begin
      rs_addr_a = {5'(r + 1), 5'(r)};
      rs_addr_b = {5'(r + 2), 5'(r + 1), 5'(r)};
      cycle();
    end
  endtask

  task automatic both_write(input logic [4:0] a, input logic [31:0] v);
    write_a = 1'b1; rd_addr_a = a; rd_a = v;
    write_b = 1'b1; rd_addr_b = a; rd_b = v;
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    write_a = 1'b0; write_b = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0; rd_a = '0; rd_b = '0;
    rs_addr_a = '0; rs_addr_b = '0;
    for (int d = 0; d < 2; d++) begin
      left_m[d] = 0;
      for (int k = 0; k < 32; k++) mem_m[d][k] = 32'h0;
    end
    repeat (2) @(posedge clk);
    model_edge(0, 1'b1, 1'b0, 0, 32'h0);
    model_edge(1, 1'b1, 1'b0, 0, 32'h0);
    #1;
    reset_a = 1'b0; reset_b = 1'b0;

    // Sweep: busy for exactly NREGS cycles, write to reg 5 dropped meanwhile.
    for (int c = 0; c < 36; c++) begin
      both_write(5'd5, 32'hDEADBEEF);
      write_a = (left_m[0] > 0);
      write_b = (left_m[1] > 0);
      rs_addr_a = 10'($urandom);
      rs_addr_b = 15'($urandom);
      cycle();
    end
    read_all();

    // Register 0: hardwired on a, ordinary on b.
    both_write(5'd0, 32'h1234);
    rs_addr_a = '0; rs_addr_b = '0;
    cycle();
    write_a = 1'b0; write_b = 1'b0;
    cycle();

    // Write reg 7 while port 0 reads it, then read it the next cycle.
    both_write(5'd7, 32'hA5A5A5A5);
    rs_addr_a = {5'd3, 5'd7}; rs_addr_b = {5'd2, 5'd1, 5'd7};
    cycle();
    write_a = 1'b0; write_b = 1'b0;
    cycle();

    // Out-of-range on b, then parallel reads of 1/1/23.
    both_write(5'd30, 32'hFF);
    rs_addr_b = {5'd30, 5'd30, 5'd30};
    cycle();
    both_write(5'd1, 32'h1111_0001);
    cycle();
    both_write(5'd23, 32'h2323_0023);
    cycle();
    write_a = 1'b0; write_b = 1'b0;
    rs_addr_b = {5'd23, 5'd1, 5'd1};
    rs_addr_a = {5'd23, 5'd1};
    cycle();

    for (int c = 0; c < 600; c++) begin
      rand_in();
      cycle();
    end

    // Fill regs with their index, then reset twice, the second at clr_cnt==10.
    for (int r = 1; r < 32; r++) begin
      both_write(5'(r), 32'(r));
      rs_addr_a = 10'($urandom);
      rs_addr_b = 15'($urandom);
      cycle();
    end
    read_all();
    reset_a = 1'b1; reset_b = 1'b1;
    cycle();
    reset_a = 1'b0; reset_b = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rand_in();
      cycle();
    end
    rand_in();
    reset_a = 1'b1; reset_b = 1'b1;
    cycle();
    for (int c = 0; c < 34; c++) begin
      rand_in();
      write_a = write_a & (left_m[0] > 0);
      write_b = write_b & (left_m[1] > 0);
      cycle();
    end
    read_all();

    for (int c = 0; c < 200; c++) begin
      rand_in();
      cycle();
    end

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending entries", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
